// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit with a start/busy/valid handshake.
// Runs on operand magnitudes and applies the sign correction in a final FIX cycle.
module mdu_seq #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      func_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] d_o,
  output logic            zero_o
);

  localparam int unsigned K  = XLEN / UNROLL;
  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [CW-1:0]   LAST = CW'(K - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state, state_nx;
  logic [2:0]        func;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0]   b;
  logic              neg_res, neg_rem;
  logic [CW-1:0]     cnt;

  logic              accept, is_div, s1, s2, neg1, neg2, div_zero, ovf, fast;
  logic [XLEN-1:0]   mag1, mag2;

  assign accept   = (state == IDLE) && start_i && !flush_i;
  assign is_div   = func_i[2];
  assign s1       = (func_i == 3'd1) || (func_i == 3'd2) || (func_i == 3'd4) || (func_i == 3'd6);
  assign s2       = (func_i == 3'd1) || (func_i == 3'd4) || (func_i == 3'd6);
  assign neg1     = s1 && op1_i[XLEN-1];
  assign neg2     = s2 && op2_i[XLEN-1];
  assign mag1     = neg1 ? -op1_i : op1_i;
  assign mag2     = neg2 ? -op2_i : op2_i;
  assign div_zero = is_div && (op2_i == '0);
  assign ovf      = ((func_i == 3'd4) || (func_i == 3'd6)) && (op1_i == MINV) && (op2_i == '1);
  assign fast     = div_zero || ovf;
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fast ? FIX : CALC;
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end

  // acc holds {hi, lo}: multiply consumes multiplier bits from lo while the
  // product grows in from the top; divide keeps {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] t;
  logic [XLEN:0]     r, s;
  logic              qb;

  always_comb begin
    t  = acc;
    r  = '0;
    s  = '0;
    qb = 1'b0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (func[2]) begin
        r  = {t[2*XLEN-1:XLEN], t[XLEN-1]};
        qb = (r >= {1'b0, b});
        if (qb) r = r - {1'b0, b};
        t  = {r[XLEN-1:0], t[XLEN-2:0], qb};
      end else begin
        s = {1'b0, t[2*XLEN-1:XLEN]} + (t[0] ? {1'b0, b} : '0);
        t = {s, t[XLEN-1:1]};
      end
    end
    acc_nx = t;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (func)
      3'd0:                res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res = quo;
      default:             res = rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      func    <= '0;
      acc     <= '0;
      b       <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      d_o     <= '0;
      zero_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        func <= func_i;
        cnt  <= '0;
        b    <= is_div ? mag2 : mag1;
        if (fast) begin
          // Fast-path results are final, so FIX must not re-sign them.
          neg_res <= 1'b0;
          neg_rem <= 1'b0;
          acc     <= div_zero ? {op1_i, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op1_i};
        end else begin
          neg_res <= neg1 ^ neg2;
          neg_rem <= neg1;
          acc     <= is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
        end
      end else if (state == CALC && !flush_i) begin
        acc <= acc_nx;
        cnt <= cnt + CW'(1);
      end else if (state == FIX && !flush_i) begin
        d_o     <= res;
        zero_o  <= (res == '0);
        valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table, hand-written handshake/abort sequences and
// randomized operations against an arithmetic reference model (32/1 and 16/4).
module tb_mdu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start, flush;
  logic [2:0]  func;
  logic [31:0] op1, op2, d;
  logic        busy, valid, zero;

  logic        start16, flush16;
  logic [2:0]  func16;
  logic [15:0] op1_16, op2_16, d16;
  logic        busy16, valid16, zero16;

  mdu_seq #(.XLEN(32), .UNROLL(1)) dut32 (
    .clk_i(clk), .resetn_i(rstn), .start_i(start), .flush_i(flush), .func_i(func),
    .op1_i(op1), .op2_i(op2), .busy_o(busy), .valid_o(valid), .d_o(d), .zero_o(zero));

  mdu_seq #(.XLEN(16), .UNROLL(4)) dut16 (
    .clk_i(clk), .resetn_i(rstn), .start_i(start16), .flush_i(flush16), .func_i(func16),
    .op1_i(op1_16), .op2_i(op2_16), .busy_o(busy16), .valid_o(valid16), .d_o(d16), .zero_o(zero16));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RISC-V M semantics computed with 64-bit integer arithmetic for width w.
  function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub, sa, sb, minv, r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua << (64 - w)) >>> (64 - w);
    sb   = (ub << (64 - w)) >>> (64 - w);
    minv = longint'(1) << (w - 1);
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: r = (ub == 0) ? -1 : (ua == minv && sb == -1) ? ua : sa / sb;
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? ua : (ua == minv && sb == -1) ? 0 : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub;
    int k;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    k    = (w == 32) ? 32 : 4;
    if (f[2] && (ub == 0 || ((f == 3'd4 || f == 3'd6) && ua == (longint'(1) << (w - 1)) && ub == mask)))
      return 1;
    return k + 1;
  endfunction

  function automatic logic get_valid(input int sel); return sel == 0 ? valid : valid16; endfunction
  function automatic logic get_busy(input int sel);  return sel == 0 ? busy  : busy16;  endfunction
  function automatic logic [31:0] get_d(input int sel); return sel == 0 ? d : {16'b0, d16}; endfunction
  function automatic logic get_zero(input int sel);  return sel == 0 ? zero  : zero16;  endfunction

  task automatic do_op(input int sel, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat     = -1;
    res     = 'x;
    z       = 1'bx;
    @(negedge clk);
    if (sel == 0) begin func = f; op1 = a; op2 = b; start = 1'b1; end
    else begin func16 = f; op1_16 = a[15:0]; op2_16 = b[15:0]; start16 = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0; start16 = 1'b0;
    if (!get_busy(sel)) busy_ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (get_valid(sel)) begin
        lat = n; res = get_d(sel); z = get_zero(sel);
        if (get_busy(sel)) busy_ok = 1'b0;
        break;
      end
      if (!get_busy(sel)) busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    int          sel;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] res, res2, exp;
  logic        z;
  int          lat, n1, n2, nvalid;
  bit          busy_ok;

  initial begin
    rstn = 1'b0; start = 1'b0; flush = 1'b0; func = '0; op1 = '0; op2 = '0;
    start16 = 1'b0; flush16 = 1'b0; func16 = '0; op1_16 = '0; op2_16 = '0;

    vecs.push_back('{0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vecs.push_back('{0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{0, 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{0, 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{0, 3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33});
    vecs.push_back('{0, 3'd7, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33});
    vecs.push_back('{0, 3'd4, 32'h12345678, 32'h12345678, 32'h00000001, 33});
    vecs.push_back('{0, 3'd6, 32'h12345678, 32'h12345678, 32'h00000000, 33});
    vecs.push_back('{0, 3'd4, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{0, 3'd6, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vecs.push_back('{0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{1, 3'd3, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 5});
    vecs.push_back('{1, 3'd5, 32'h0000FFF9, 32'h00000002, 32'h00007FFC, 5});
    vecs.push_back('{1, 3'd4, 32'h00001234, 32'h00000000, 32'h0000FFFF, 1});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_d", d, 0);
    chk("reset_zero", zero, 1);
    @(negedge clk) rstn = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].sel, vecs[i].f, vecs[i].a, vecs[i].b, res, z, lat, busy_ok);
      chk($sformatf("vec%0d_d", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].exp == 0);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), get_valid(vecs[i].sel), 0);
    end

    for (int i = 0; i < 60; i++) begin
      int          sel, w;
      logic [2:0]  f;
      logic [31:0] a, b;
      sel = i % 2;
      w   = (sel == 0) ? 32 : 16;
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = (sel == 0) ? 32'h80000000 : 32'h8000; b = '1; end
        2: b = b & 32'hF;
        default: ;
      endcase
      if (sel == 1) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
      exp = ref_op(w, f, a, b);
      do_op(sel, f, a, b, res, z, lat, busy_ok);
      chk($sformatf("rnd%0d_f%0d_d", i, f), res, exp);
      chk($sformatf("rnd%0d_zero", i), z, exp == 0);
      chk($sformatf("rnd%0d_lat", i), lat, ref_lat(w, f, a, b));
      chk($sformatf("rnd%0d_busy", i), busy_ok, 1);
    end

    // start pulsed mid-operation must be ignored and not queued
    @(negedge clk); func = 3'd5; op1 = 32'd1000000; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); func = 3'd0; op1 = 32'd3; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int n = 12; n <= 100; n++) begin
      @(posedge clk); #1;
      if (valid) begin lat = n; res = d; break; end
    end
    chk("ign_d", res, 32'd142857);
    chk("ign_lat", lat, 33);
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) nvalid++; end
    chk("ign_noqueue", nvalid, 0);

    // start held high across valid: back-to-back accept
    @(negedge clk); func = 3'd0; op1 = 32'd7; op2 = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    func = 3'd5; op1 = 32'd100; op2 = 32'd7;
    n1 = -1; n2 = -1;
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk); #1;
      if (n1 >= 0 && n == n1 + 1) start = 1'b0;
      if (valid) begin
        if (n1 < 0) begin n1 = n; res = d; end
        else begin n2 = n; res2 = d; break; end
      end
    end
    start = 1'b0;
    chk("b2b_first_d", res, 32'd42);
    chk("b2b_first_lat", n1, 33);
    chk("b2b_second_d", res2, 32'd14);
    chk("b2b_gap", n2 - n1, 34);

    // flush mid-CALC keeps d_o/zero_o and produces no valid
    do_op(0, 3'd0, 32'd3, 32'd5, res, z, lat, busy_ok);
    chk("pre_flush_d", res, 32'd15);
    @(negedge clk); func = 3'd4; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) nvalid++; end
    chk("flush_novalid", nvalid, 0);
    chk("flush_d", d, 32'd15);
    chk("flush_zero", zero, 0);

    // asynchronous reset mid-CALC
    @(negedge clk); func = 3'd0; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_d", d, 0);
    chk("arst_zero", zero, 1);
    chk("arst_valid", valid, 0);
    @(negedge clk) rstn = 1'b1;
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (valid || busy) nvalid++; end
    chk("arst_quiet", nvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
